// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve queue.
//   brq_entry_t : one in-flight branch (PC plus predicted direction)
//   brq_state_e : queue control state (RUN accepts branches, DRAIN follows a flush)
//   INSN_BYTES  : instruction size, used for the not-taken fall-through PC
//   BP_PC_W     : PC width carried by brq_entry_t
package bp_pkg;

  localparam int BP_PC_W    = 32;
  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               pred;
  } brq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } brq_state_e;

endpackage

// File: rtl/bp_fifo.sv
// Pointer/storage FIFO with a synchronous clear.
//   clk, rst : clock, asynchronous active-low reset
//   push     : write wdata at the tail
//   wdata    : entry to write
//   pop      : retire the head entry
//   clear    : discard all entries (wins over push and pop)
//   rdata    : current head entry (valid when count != 0)
//   count    : live entries, 0..DEPTH
// Pointers carry one extra MSB so that full (count == DEPTH) and empty
// (count == 0) are distinguishable. A push and a pop in the same cycle while
// full is legal: the write lands in the slot the head is vacating.
module bp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     clear,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic [W-1:0] mem_q [DEPTH];

  // NOTE: pointers use non-blocking assignments so every register samples
  // the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // slots hold live data, so resetting the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign count = wptr_q - rptr_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight conditional branches between fetch and execute.
//   clk, rst     : clock, asynchronous active-low reset
//   enq_vld/pc/pred, enq_rdy : fetch pushes a branch PC and predicted direction
//   res_vld/taken/target     : execute resolves the oldest branch
//   upd_vld/pc/taken         : registered predictor training update
//   flush, flush_pc          : one-cycle mispredict redirect
//   occupancy                : live entries
//   mispred_cnt              : saturating mispredict count
//   err_underrun             : sticky, a resolve arrived with the queue empty
// A mispredict clears the whole queue (younger branches are wrong-path) and
// the control FSM spends one DRAIN cycle refusing new branches while fetch
// redirects. Only enq_rdy is combinational from inputs; all other outputs
// are registered.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = BP_PC_W,  // must match the entry layout in bp_pkg
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_vld,
  input  logic [PC_W-1:0]            enq_pc,
  input  logic                       enq_pred,
  output logic                       enq_rdy,
  input  logic                       res_vld,
  input  logic                       res_taken,
  input  logic [PC_W-1:0]            res_target,
  output logic                       upd_vld,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       upd_taken,
  output logic                       flush,
  output logic [PC_W-1:0]            flush_pc,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           mispred_cnt,
  output logic                       err_underrun
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  brq_state_e        state_q;
  logic              alive_q;
  logic              upd_vld_q;
  logic [PC_W-1:0]   upd_pc_q;
  logic              upd_taken_q;
  logic              flush_q;
  logic [PC_W-1:0]   flush_pc_q;
  logic [CNT_W-1:0]  mispred_cnt_q;
  logic [CNT_W-1:0]  mispred_cnt_d;
  logic              err_q;

  brq_entry_t        enq_entry;
  brq_entry_t        head;
  logic [OCC_W-1:0]  count;
  logic              pop;
  logic              mispredict;
  logic              push;

  assign enq_entry = '{pc: enq_pc, pred: enq_pred};

  assign pop        = res_vld && (count != '0);
  assign mispredict = pop && (res_taken != head.pred);

  // alive_q is low throughout reset and for the release cycle, so enq_rdy
  // stays 0 while rst is asserted. A pop frees a slot in the same cycle,
  // which lets a full queue accept a new branch.
  assign enq_rdy = alive_q && (state_q == RUN) &&
                   ((count != OCC_W'(DEPTH)) || pop);

  // A mispredict makes any same-cycle push wrong-path, so it is dropped.
  assign push = enq_vld && enq_rdy && !mispredict;

  bp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(brq_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enq_entry),
    .pop   (pop),
    .clear (mispredict),
    .rdata (head),
    .count (count)
  );

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      alive_q       <= 1'b0;
      upd_vld_q     <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      flush_q       <= 1'b0;
      flush_pc_q    <= '0;
      mispred_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      alive_q       <= 1'b1;
      upd_vld_q     <= pop;
      flush_q       <= mispredict;
      mispred_cnt_q <= mispred_cnt_d;

      if (pop) begin
        upd_pc_q    <= head.pc;
        upd_taken_q <= res_taken;
      end

      if (mispredict) begin
        flush_pc_q <= res_taken ? res_target : head.pc + PC_W'(INSN_BYTES);
      end

      if (res_vld && (count == '0)) err_q <= 1'b1;

      case (state_q)
        RUN:     if (mispredict) state_q <= DRAIN;
        DRAIN:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign upd_vld      = upd_vld_q;
  assign upd_pc       = upd_pc_q;
  assign upd_taken    = upd_taken_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;
  assign occupancy    = count;
  assign mispred_cnt  = mispred_cnt_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue. A narrow mispredict counter
// (CNT_W=4) lets saturation at all-ones be reached in a few dozen cycles.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic              clk;
  logic              rst;
  logic              enq_vld;
  logic [PC_W-1:0]   enq_pc;
  logic              enq_pred;
  logic              enq_rdy;
  logic              res_vld;
  logic              res_taken;
  logic [PC_W-1:0]   res_target;
  logic              upd_vld;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic              flush;
  logic [PC_W-1:0]   flush_pc;
  logic [2:0]        occupancy;
  logic [CNT_W-1:0]  mispred_cnt;
  logic              err_underrun;

  branch_resolve_queue #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enq_vld      (enq_vld),
    .enq_pc       (enq_pc),
    .enq_pred     (enq_pred),
    .enq_rdy      (enq_rdy),
    .res_vld      (res_vld),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .upd_vld      (upd_vld),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .occupancy    (occupancy),
    .mispred_cnt  (mispred_cnt),
    .err_underrun (err_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs held for one cycle, enq_rdy expected before the edge,
  // everything else expected just after it.
  typedef struct {
    logic              ev;
    logic [31:0]       pc;
    logic              pred;
    logic              rv;
    logic              rt;
    logic [31:0]       tgt;
    logic              rdy;
    logic              uv;
    logic [31:0]       upc;
    logic              ut;
    logic              fl;
    logic [31:0]       fpc;
    logic [2:0]        occ;
    logic [CNT_W-1:0]  cnt;
    logic              err;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int ev, input int pc, input int pred,
                              input int rv, input int rt, input int tgt,
                              input int rdy, input int uv, input int upc,
                              input int ut, input int fl, input int fpc,
                              input int occ, input int cnt, input int err);
    vec_t v;
    v.ev   = 1'(ev);   v.pc  = 32'(pc);  v.pred = 1'(pred);
    v.rv   = 1'(rv);   v.rt  = 1'(rt);   v.tgt  = 32'(tgt);
    v.rdy  = 1'(rdy);  v.uv  = 1'(uv);   v.upc  = 32'(upc);
    v.ut   = 1'(ut);   v.fl  = 1'(fl);   v.fpc  = 32'(fpc);
    v.occ  = 3'(occ);  v.cnt = CNT_W'(cnt); v.err = 1'(err);
    return v;
  endfunction

  task automatic drive(input logic ev, input logic [31:0] pc, input logic pred,
                       input logic rv, input logic rt, input logic [31:0] tgt);
    enq_vld    = ev;
    enq_pc     = pc;
    enq_pred   = pred;
    res_vld    = rv;
    res_taken  = rt;
    res_target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             ev pc           pr rv rt tgt    rdy uv upc          ut fl fpc    occ cnt err
    vecs[0]  = mk(1, 'h100,       1, 0, 0, 0,     1,  0, 0,           0, 0, 0,     1,  0,  0);
    vecs[1]  = mk(0, 0,           0, 1, 1, 0,     1,  1, 'h100,       1, 0, 0,     0,  0,  0);
    vecs[2]  = mk(0, 0,           0, 0, 0, 0,     1,  0, 0,           0, 0, 0,     0,  0,  0);
    vecs[3]  = mk(1, 'h200,       1, 0, 0, 0,     1,  0, 0,           0, 0, 0,     1,  0,  0);
    vecs[4]  = mk(1, 'h300,       0, 0, 0, 0,     1,  0, 0,           0, 0, 0,     2,  0,  0);
    vecs[5]  = mk(0, 0,           0, 1, 0, 0,     1,  1, 'h200,       0, 1, 'h204, 0,  1,  0);
    vecs[6]  = mk(1, 'h999,       1, 0, 0, 0,     0,  0, 0,           0, 0, 0,     0,  1,  0);
    vecs[7]  = mk(1, 'h40,        0, 0, 0, 0,     1,  0, 0,           0, 0, 0,     1,  1,  0);
    vecs[8]  = mk(0, 0,           0, 1, 1, 'h800, 1,  1, 'h40,        1, 1, 'h800, 0,  2,  0);
    vecs[9]  = mk(0, 0,           0, 0, 0, 0,     0,  0, 0,           0, 0, 0,     0,  2,  0);
    vecs[10] = mk(1, 'h10,        0, 0, 0, 0,     1,  0, 0,           0, 0, 0,     1,  2,  0);
    vecs[11] = mk(1, 'h20,        1, 0, 0, 0,     1,  0, 0,           0, 0, 0,     2,  2,  0);
    vecs[12] = mk(1, 'h30,        0, 0, 0, 0,     1,  0, 0,           0, 0, 0,     3,  2,  0);
    vecs[13] = mk(1, 'h40,        1, 0, 0, 0,     1,  0, 0,           0, 0, 0,     4,  2,  0);
    vecs[14] = mk(1, 'h50,        0, 0, 0, 0,     0,  0, 0,           0, 0, 0,     4,  2,  0);
    vecs[15] = mk(1, 'h50,        0, 1, 0, 0,     1,  1, 'h10,        0, 0, 0,     4,  2,  0);
    vecs[16] = mk(0, 0,           0, 1, 1, 0,     1,  1, 'h20,        1, 0, 0,     3,  2,  0);
    vecs[17] = mk(0, 0,           0, 1, 0, 0,     1,  1, 'h30,        0, 0, 0,     2,  2,  0);
    vecs[18] = mk(0, 0,           0, 1, 1, 0,     1,  1, 'h40,        1, 0, 0,     1,  2,  0);
    vecs[19] = mk(0, 0,           0, 1, 0, 0,     1,  1, 'h50,        0, 0, 0,     0,  2,  0);
    vecs[20] = mk(0, 0,           0, 1, 1, 0,     1,  0, 0,           0, 0, 0,     0,  2,  1);
    vecs[21] = mk(0, 0,           0, 0, 0, 0,     1,  0, 0,           0, 0, 0,     0,  2,  1);
    vecs[22] = mk(1, 'h60,        1, 0, 0, 0,     1,  0, 0,           0, 0, 0,     1,  2,  1);
    vecs[23] = mk(1, 'h70,        0, 1, 0, 0,     1,  1, 'h60,        0, 1, 'h64,  0,  3,  1);
    vecs[24] = mk(0, 0,           0, 0, 0, 0,     0,  0, 0,           0, 0, 0,     0,  3,  1);
    vecs[25] = mk(0, 0,           0, 0, 0, 0,     1,  0, 0,           0, 0, 0,     0,  3,  1);
    vecs[26] = mk(1, 'hFFFFFFFC,  1, 0, 0, 0,     1,  0, 0,           0, 0, 0,     1,  3,  1);
    vecs[27] = mk(0, 0,           0, 1, 0, 0,     1,  1, 'hFFFFFFFC,  0, 1, 'h0,   0,  4,  1);
    vecs[28] = mk(0, 0,           0, 0, 0, 0,     0,  0, 0,           0, 0, 0,     0,  4,  1);

    // Reset: everything quiet, enq_rdy held low.
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset occupancy", 32'(occupancy), 32'd0);
    check("reset flush",     32'(flush),     32'd0);
    check("reset upd_vld",   32'(upd_vld),   32'd0);
    check("reset enq_rdy",   32'(enq_rdy),   32'd0);
    check("reset cnt",       32'(mispred_cnt), 32'd0);
    rst = 1'b1;
    tick();
    check("release enq_rdy", 32'(enq_rdy), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ev, vecs[i].pc, vecs[i].pred,
            vecs[i].rv, vecs[i].rt, vecs[i].tgt);
      #1;
      check($sformatf("row%0d enq_rdy", i), 32'(enq_rdy), 32'(vecs[i].rdy));
      tick();
      check($sformatf("row%0d upd_vld", i),   32'(upd_vld),      32'(vecs[i].uv));
      check($sformatf("row%0d flush", i),     32'(flush),        32'(vecs[i].fl));
      check($sformatf("row%0d occupancy", i), 32'(occupancy),    32'(vecs[i].occ));
      check($sformatf("row%0d cnt", i),       32'(mispred_cnt),  32'(vecs[i].cnt));
      check($sformatf("row%0d underrun", i),  32'(err_underrun), 32'(vecs[i].err));
      if (vecs[i].uv) begin
        check($sformatf("row%0d upd_pc", i),    upd_pc,           vecs[i].upc);
        check($sformatf("row%0d upd_taken", i), 32'(upd_taken),   32'(vecs[i].ut));
      end
      if (vecs[i].fl) begin
        check($sformatf("row%0d flush_pc", i), flush_pc, vecs[i].fpc);
      end
    end

    // Counter saturation: mispredicts 5..15 count up, the next one holds.
    for (int k = 5; k <= 16; k++) begin
      drive(1'b1, 32'h1000 + 32'(k * 16), 1'b1, 1'b0, 1'b0, '0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
      tick();
      check($sformatf("sat%0d flush", k), 32'(flush), 32'd1);
      check($sformatf("sat%0d cnt", k), 32'(mispred_cnt),
            (k > 15) ? 32'd15 : 32'(k));
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
      tick();
    end

    // Reset mid-operation cancels a pending update and flush at once.
    drive(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 32'h3000, 1'b0, 1'b1, 1'b0, '0);
    tick();
    check("pre-reset flush",   32'(flush),   32'd1);
    check("pre-reset upd_vld", 32'(upd_vld), 32'd1);
    rst = 1'b0;
    #1;
    check("midreset flush",     32'(flush),        32'd0);
    check("midreset upd_vld",   32'(upd_vld),      32'd0);
    check("midreset occupancy", 32'(occupancy),    32'd0);
    check("midreset cnt",       32'(mispred_cnt),  32'd0);
    check("midreset underrun",  32'(err_underrun), 32'd0);
    check("midreset enq_rdy",   32'(enq_rdy),      32'd0);
    drive(1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("held reset occupancy", 32'(occupancy), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    check("rerelease enq_rdy", 32'(enq_rdy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
